// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and byte-lane helpers for the data memory responder.
package dmem_pkg;

    // Access width encodings (2'd3 behaves as a word)
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    // Responder FSM states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Byte enables for a store of the given width at the given low address bits
    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] a);
        case (width)
            W_BYTE:  return 4'b0001 << a;
            W_HALF:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it might land on
    function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] d);
        case (width)
            W_BYTE:  return {4{d[7:0]}};
            W_HALF:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Pick the addressed byte/half out of a word, right-align it and extend
    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] width,
                                               input logic [1:0] a, input logic ext);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (width)
            W_BYTE:  return {{24{ext & b[7]}}, b};
            W_HALF:  return {{16{ext & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 single-port RAM, byte write enables, synchronous read.
module dmem_array #(
    parameter int DEPTH     = 4096,
    parameter     INIT_FILE = "",
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Single access port: byte-masked write and read of the old word on the same edge
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target side of the dcache request/valid handshake. Holds each
// request for LATENCY cycles, then pulses dcache_valid with load data.
// Optional build macro DMEM_RANDOM_STALL_EN adds 0..7 LFSR-driven wait cycles.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dcache_r_ena,
    input  logic        dcache_w_ena,
    input  logic        dcache_ext,
    input  logic [1:0]  dcache_width,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_data_in,
    output logic        dcache_valid,
    output logic [31:0] dcache_data_out
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    state;
    logic [4:0]    cnt;
    logic [AW+1:0] req_addr;
    logic [1:0]    req_width;
    logic          req_ext;
    logic          req_store;
    logic [31:0]   req_data;

    logic          accept;
    logic          to_resp;
    logic [4:0]    wait_cycles;
    logic [AW+1:0] acc_addr;
    logic [1:0]    acc_width;
    logic          acc_store;
    logic [31:0]   acc_data;
    logic [31:0]   rdata;
    logic          unused_addr_hi;

    // Address bits above the array wrap back onto it
    assign unused_addr_hi = ^dcache_addr[31:AW+2];

    assign accept = (state == IDLE) && (dcache_r_ena || dcache_w_ena);

`ifdef DMEM_RANDOM_STALL_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign wait_cycles = 5'(LATENCY - 1) + {2'b00, lfsr[2:0]};
`else
    assign wait_cycles = 5'(LATENCY - 1);
`endif

    // RAM is touched on exactly the edge that enters RESP
    assign to_resp = accept ? (wait_cycles == 5'd0) : ((state == WAIT) && (cnt == 5'd1));

    // With zero wait the access happens on the sampling edge, so use the live inputs
    always_comb begin
        acc_addr  = req_addr;
        acc_width = req_width;
        acc_store = req_store;
        acc_data  = req_data;
        if (state == IDLE) begin
            acc_addr  = dcache_addr[AW+1:0];
            acc_width = dcache_width;
            acc_store = dcache_w_ena;
            acc_data  = dcache_data_in;
        end
    end

    dmem_array #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_array (
        .clk   (clk),
        .en    (to_resp),
        .we    (acc_store ? lane_mask(acc_width, acc_addr[1:0]) : 4'b0000),
        .addr  (acc_addr[AW+1:2]),
        .wdata (store_lanes(acc_width, acc_data)),
        .rdata (rdata)
    );

    // Request capture and IDLE -> WAIT -> RESP -> IDLE sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            req_addr  <= '0;
            req_width <= W_WORD;
            req_ext   <= 1'b0;
            req_store <= 1'b0;
            req_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_addr  <= dcache_addr[AW+1:0];
                    req_width <= dcache_width;
                    req_ext   <= dcache_ext;
                    req_store <= dcache_w_ena;
                    req_data  <= dcache_data_in;
                    cnt       <= wait_cycles;
                    state     <= to_resp ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 5'd1;
                    if (to_resp) state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dcache_valid    = (state == RESP);
    assign dcache_data_out = (dcache_valid && !req_store)
                           ? load_align(rdata, req_width, req_addr[1:0], req_ext) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench; expected data and due cycle are queued
// when a request is driven and compared when dcache_valid appears.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r_ena = 1'b0, w_ena = 1'b0, ext = 1'b0;
    logic [1:0]  width = W_WORD;
    logic [31:0] addr = 32'd0, din = 32'd0;
    logic        valid;
    logic [31:0] dout;

    logic        b_r_ena = 1'b0;
    logic        b_zero  = 1'b0;
    logic [1:0]  b_width = W_WORD;
    logic [31:0] b_word  = 32'd0;
    logic        b_valid;
    logic [31:0] b_dout;

    int checks = 0, failures = 0;
    int cyc = 0;

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(4096), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .dcache_r_ena(r_ena), .dcache_w_ena(w_ena),
        .dcache_ext(ext), .dcache_width(width), .dcache_addr(addr),
        .dcache_data_in(din), .dcache_valid(valid), .dcache_data_out(dout)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(1)) u_b2b (
        .clk(clk), .rst(rst), .dcache_r_ena(b_r_ena), .dcache_w_ena(b_zero),
        .dcache_ext(b_zero), .dcache_width(b_width), .dcache_addr(b_word),
        .dcache_data_in(b_word), .dcache_valid(b_valid), .dcache_data_out(b_dout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst && valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out", dout, e.data);
                chk("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic access(input logic r, input logic w, input logic e, input logic [1:0] wd,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] expd);
        bit got = 0;
        @(negedge clk);
        r_ena = r; w_ena = w; ext = e; width = wd; addr = a; din = d;
        sb.push_back('{expd, cyc + 2});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) begin got = 1; break; end
        end
        if (!got) begin
            chk("timeout", 32'd0, 32'd1);
            sb.delete();
        end
        r_ena = 1'b0; w_ena = 1'b0;
    endtask

    initial begin
        int vcount, consec;
        logic prev;
        #1;
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_dout", dout, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // word store then load
        access(0, 1, 0, W_WORD, 32'h10, 32'hDEADBEEF, 32'h0);
        access(1, 0, 0, W_WORD, 32'h10, 32'h0, 32'hDEADBEEF);
        // byte lane 3 with both extensions
        access(0, 1, 0, W_WORD, 32'h10, 32'h0, 32'h0);
        access(0, 1, 0, W_BYTE, 32'h13, 32'h80, 32'h0);
        access(1, 0, 1, W_BYTE, 32'h13, 32'h0, 32'hFFFFFF80);
        access(1, 0, 0, W_BYTE, 32'h13, 32'h0, 32'h00000080);
        access(1, 0, 0, W_WORD, 32'h10, 32'h0, 32'h80000000);
        access(1, 0, 0, 2'd3,   32'h12, 32'h0, 32'h80000000);
        // upper half
        access(0, 1, 0, W_WORD, 32'h20, 32'h0, 32'h0);
        access(0, 1, 0, W_HALF, 32'h22, 32'h8001, 32'h0);
        access(1, 0, 1, W_HALF, 32'h22, 32'h0, 32'hFFFF8001);
        access(1, 0, 0, W_HALF, 32'h20, 32'h0, 32'h00000000);
        access(1, 0, 1, W_HALF, 32'h23, 32'h0, 32'hFFFF8001);
        // address wrap at DEPTH*4
        access(0, 1, 0, W_WORD, 32'h00004004, 32'h12345678, 32'h0);
        access(1, 0, 0, W_WORD, 32'h00000004, 32'h0, 32'h12345678);
        // read and write together counts as a store
        access(1, 1, 1, W_WORD, 32'h40, 32'hCAFEF00D, 32'h0);
        access(1, 0, 0, W_WORD, 32'h40, 32'h0, 32'hCAFEF00D);
        @(negedge clk);
        chk("idle_dout", dout, 32'd0);

        // reset during WAIT drops the store
        access(0, 1, 0, W_WORD, 32'h30, 32'h11223344, 32'h0);
        @(negedge clk);
        w_ena = 1'b1; width = W_WORD; addr = 32'h30; din = 32'hA5A5A5A5;
        @(negedge clk);
        rst = 1'b0; w_ena = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, valid}, 32'd0);
        chk("rst_mid_dout", dout, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        access(1, 0, 0, W_WORD, 32'h30, 32'h0, 32'h11223344);

        // LATENCY=1 with request held through RESP
        @(negedge clk);
        b_r_ena = 1'b1;
        vcount = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_valid) vcount++;
            if (b_valid && prev) consec++;
            prev = b_valid;
        end
        b_r_ena = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_count", 32'(vcount), 32'd5);
        chk("b2b_consecutive", 32'(consec), 32'd0);
        chk("b2b_quiet", {31'd0, b_valid}, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
